serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 71 +++++++
 tb/tb_serial_adder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants and types for the serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_MAX_BITS = 32;

  // bit_cnt has to reach MAX_BITS+1, so it needs room for MAX_BITS+2 values.
  function automatic int cnt_width(input int max_bits);
    return $clog2(max_bits + 2);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_MAX_BITS);

  typedef logic [DEFAULT_MAX_BITS:0] sum_t;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder used as the serial adder's datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder (LSB first) with a parallel capture register for the emitted sum bits.
// Optional SERIAL_ADDER_CIN_EN adds a cin input that seeds the carry on clean.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int MAX_BITS = DEFAULT_MAX_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             a,
  input  logic                             b,
  input  logic                             clean,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic                             cin,
`endif
  output logic                             s,
  output logic                             cout,
  output logic [MAX_BITS:0]                sum,
  output logic [cnt_width(MAX_BITS)-1:0]   bit_cnt,
  output logic                             ovf
);

  localparam int CW = cnt_width(MAX_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic s_next;
  logic c_next;
  logic clean_carry;

  full_adder_cell u_fa (
    .a  (a),
    .b  (b),
    .ci (cout),
    .s  (s_next),
    .co (c_next)
  );

`ifdef SERIAL_ADDER_CIN_EN
  assign clean_carry = cin;
`else
  assign clean_carry = 1'b0;
`endif

  // Once bit_cnt saturates the capture register freezes but the serial path keeps running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s       <= 1'b0;
      cout    <= 1'b0;
      sum     <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clean) begin
      s       <= 1'b0;
      cout    <= clean_carry;
      sum     <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      s    <= s_next;
      cout <= c_next;
      if (bit_cnt < CNT_MAX) begin
        sum     <= sum | ({{MAX_BITS{1'b0}}, s_next} << bit_cnt);
        bit_cnt <= bit_cnt + CNT_ONE;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: drivers queue hand-computed expectations, a monitor checks them.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int MB = DEFAULT_MAX_BITS;
  localparam int CW = CNT_W;
  // entry layout: {full_check, s, cout, ovf, bit_cnt, sum}
  localparam int W  = 4 + CW + MB + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic clean = 1'b0;
`ifdef SERIAL_ADDER_CIN_EN
  logic cin = 1'b0;
`endif
  logic s;
  logic cout;
  logic ovf;
  sum_t sum;
  logic [CW-1:0] bit_cnt;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  serial_adder #(.MAX_BITS(MB)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .clean   (clean),
`ifdef SERIAL_ADDER_CIN_EN
    .cin     (cin),
`endif
    .s       (s),
    .cout    (cout),
    .sum     (sum),
    .bit_cnt (bit_cnt),
    .ovf     (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs and queue the outputs expected after the next edge
  task automatic drive(input logic ia, input logic ib, input logic icl,
                       input logic es, input logic ec,
                       input logic full = 1'b0, input logic eo = 1'b0,
                       input logic [CW-1:0] ecnt = '0, input sum_t esum = '0);
    @(negedge clk);
    a = ia;
    b = ib;
    clean = icl;
    exp_q.push_back({full, es, ec, eo, ecnt, esum});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s"}, 64'(s), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cnt"}, 64'(bit_cnt), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  // monitor: one expectation per clock edge
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("s", 64'(s), 64'(e[W-2]));
      check("cout", 64'(cout), 64'(e[W-3]));
      if (e[W-1]) begin
        check("ovf", 64'(ovf), 64'(e[W-4]));
        check("bit_cnt", 64'(bit_cnt), 64'(e[MB+1 +: CW]));
        check("sum", 64'(sum), 64'(e[MB:0]));
      end
    end
  end

  sum_t ovf_sum;

  initial begin
    ovf_sum = {{MB{1'b1}}, 1'b0};

    // reset then clean pulse
    #2 reset = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);

    // 15 + 13 = 28
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 1, 1);
    drive(1, 1, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 1, 0, 5, 28);
    drive(0, 0, 0, 0, 0, 1, 0, 6, 28);

    // 27 + 17 = 44
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1, 0, 6, 44);

    // clean while carry pending, then a fresh addition
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 1, 1);
    drive(1, 1, 1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 0, 1, 1);

    // saturation and overflow
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < MB + 3; i++)
      drive(1, 1, 0, (i != 0), 1, (i >= MB), (i > MB), CW'(MB + 1), ovf_sum);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0);

    // reset in the middle of an addition
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 0, 1, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_zero("midreset");
    reset = 1'b1;
    drive(1, 0, 0, 1, 0, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 2, 1);

`ifdef SERIAL_ADDER_CIN_EN
    // carry-in seeded by clean
    cin = 1'b1;
    drive(0, 0, 1, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0, 1, 1);
    @(posedge clk);
    cin = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 2, 1);
`endif

    // bounded drain of the scoreboard
    repeat (5) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
